// File: rtl/data_memory_pkg.sv
// Shared constants for the arbitrated data memory: default geometry, RW encoding, byte lane width.
package data_memory_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 16;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 14;
    localparam int unsigned BYTE_WIDTH         = 8;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Index width that stays legal for a single port.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/data_memory_arb_if.sv
// Multi-port req/gnt bus between requesters and data_memory_arb; all ports packed per signal.
interface data_memory_arb_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned NUM_PORTS  = 2
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic [NUM_PORTS-1:0]            req;
    logic [NUM_PORTS-1:0]            RW;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] address;
    logic [NUM_PORTS*DATA_WIDTH-1:0] data_in;
    logic [NUM_PORTS*BE_WIDTH-1:0]   be;
    logic [NUM_PORTS-1:0]            gnt;
    logic [NUM_PORTS-1:0]            rvalid;
    logic [DATA_WIDTH-1:0]           data_out;

    modport master (
        output req, RW, address, data_in, be,
        input  gnt, rvalid, data_out
    );

    modport slave (
        input  req, RW, address, data_in, be,
        output gnt, rvalid, data_out
    );

endinterface

// File: rtl/data_memory_arbiter.sv
// Grant selection for data_memory_arb: fixed priority (port 0 first) by default,
// round-robin when DATA_MEMORY_ARB_RR_EN is defined.
module data_memory_arbiter import data_memory_pkg::*; #(
    parameter  int unsigned NUM_PORTS = 2,
    localparam int unsigned IdxW      = idx_width(NUM_PORTS)
) (
`ifdef DATA_MEMORY_ARB_RR_EN
    input  logic                 clk,
    input  logic                 rst_n,
`endif
    input  logic [NUM_PORTS-1:0] req_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [IdxW-1:0]      gnt_idx_o
);

    logic [IdxW-1:0] prio_base;
    int unsigned     idx;
    logic            found;

`ifdef DATA_MEMORY_ARB_RR_EN
    logic [IdxW-1:0] ptr_q, ptr_d;

    // Any grant is a completed transfer, since grant implies request.
    always_comb begin
        ptr_d = ptr_q;
        if (|gnt_o) begin
            ptr_d = (gnt_idx_o == IdxW'(NUM_PORTS - 1)) ? '0 : gnt_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign prio_base = ptr_q;
`else
    assign prio_base = '0;
`endif

    // Scan ports starting at prio_base, wrapping; first requester wins.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            idx = 32'(prio_base) + i;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = IdxW'(idx);
            end
        end
    end

endmodule

// File: rtl/data_memory_arb.sv
// Word-addressed RAM shared by NUM_PORTS requesters with byte enables and registered reads.
// Build option: DATA_MEMORY_ARB_RR_EN selects round-robin arbitration instead of fixed priority.
module data_memory_arb import data_memory_pkg::*; #(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned NUM_PORTS  = 2
) (
    input logic              clk,
    input logic              rst_n,
    data_memory_arb_if.slave bus
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned IdxW     = idx_width(NUM_PORTS);
    localparam int unsigned Depth    = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [Depth];

    logic [NUM_PORTS-1:0]  gnt;
    logic [IdxW-1:0]       gnt_idx;
    logic                  gnt_any;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [BE_WIDTH-1:0]   sel_be;
    logic                  sel_rw;
    logic                  wr_en;
    logic                  rd_en;

    logic [NUM_PORTS-1:0]  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

    data_memory_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arbiter (
`ifdef DATA_MEMORY_ARB_RR_EN
        .clk       (clk),
        .rst_n     (rst_n),
`endif
        .req_i     (bus.req),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign gnt_any   = |gnt;
    assign sel_addr  = bus.address[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata = bus.data_in[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    assign sel_be    = bus.be[gnt_idx*BE_WIDTH +: BE_WIDTH];
    assign sel_rw    = bus.RW[gnt_idx];
    assign wr_en     = gnt_any && (sel_rw == RW_WRITE);
    assign rd_en     = gnt_any && (sel_rw == RW_READ);

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < BE_WIDTH; b++) begin
                if (sel_be[b]) begin
                    mem_q[sel_addr][b*BYTE_WIDTH +: BYTE_WIDTH] <=
                        sel_wdata[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_comb begin
        rvalid_d   = rd_en ? gnt : '0;
        data_out_d = rd_en ? mem_q[sel_addr] : data_out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q   <= '0;
            data_out_q <= '0;
        end else begin
            rvalid_q   <= rvalid_d;
            data_out_q <= data_out_d;
        end
    end

    assign bus.gnt      = gnt;
    assign bus.rvalid   = rvalid_q;
    assign bus.data_out = data_out_q;

endmodule

// File: doc/data_memory_arb.md
# data_memory_arb

Parametrised successor to the single-port `data_memory`: a synchronous word-addressed RAM shared by `NUM_PORTS` requesters (default 2, e.g. CPU data path and DMA) through a req/gnt handshake. It adds per-byte write enables, a registered one-cycle read path with a per-port valid strobe, and arbitration. It sits between the core's load/store unit and the on-chip data store and replaces direct `data_memory` instantiation.

## Interface
- `DATA_WIDTH`, 16, word width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 14, word address width; depth = 2**ADDR_WIDTH.
- `NUM_PORTS`, 2, number of requester ports, 1..8.
- `BE_WIDTH`, DATA_WIDTH/8, byte enables per word (derived; do not override).

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  NUM_PORTS  per-port request.
- `RW`  in  NUM_PORTS  per-port direction: 1 = read, 0 = write (matches `data_memory`).
- `address`  in  NUM_PORTS*ADDR_WIDTH  packed per-port word address; port p at [p*ADDR_WIDTH +: ADDR_WIDTH].
- `data_in`  in  NUM_PORTS*DATA_WIDTH  packed per-port write data.
- `be`  in  NUM_PORTS*BE_WIDTH  packed per-port byte enables; bit i covers data bits [8i+7:8i]. Ignored on reads.
- `gnt`  out  NUM_PORTS  one-hot-or-zero grant, combinational from `req` and arbiter state.
- `rvalid`  out  NUM_PORTS  one-hot-or-zero, high one cycle after a read grant.
- `data_out`  out  DATA_WIDTH  shared registered read data, qualified by `rvalid`.

## Operation
- Single physical array; at most one access per cycle.
- Handshake: requester holds `req`, `RW`, `address`, `data_in`, `be` stable until it sees `gnt` high; transfer completes on the rising edge where `req & gnt`. Requester may drop or change the request on the next cycle.
- `gnt[p]` only when `req[p]`; never more than one bit set; zero when `req` is zero.
- Write: on the granted edge, bytes with `be[i]=1` are updated, others kept. `be`=0 is a legal no-op write that still consumes the grant.
- Read: on the granted edge, `data_out` loads mem[address] and `rvalid[p]` is set for exactly one cycle; `data_out` holds its value until the next read completes.
- Arbitration (see Configuration): fixed priority, lowest index wins; or round-robin.
- Addresses cover the full array; no out-of-range case exists.
- Memory contents are not reset; unwritten locations read X in simulation.

## Timing
- Reset (async assert, sync-released by system): `data_out`=0, `rvalid`=0, RR pointer = port 0 highest priority. `gnt` reflects `req` immediately after release.
- Read latency: 1 cycle from granted edge to `rvalid`/`data_out`. Back-to-back reads from the same or different ports give one result per cycle.
- Write latency: 0; a read granted the cycle after a write to the same address returns the new data.
- Same-cycle write and read from different ports: serialised by arbitration; loser keeps `req` and is served on a later cycle.
- Reset asserted mid-operation: in-flight read discarded (`rvalid` forced 0 immediately); a write on the edge coincident with reset assertion is not guaranteed.
- Throughput: 1 access/cycle total; no idle bubble on grant handover.

## Configuration
- `DATA_MEMORY_ARB_RR_EN` defined: round-robin; after a grant to port p, priority order becomes p+1, p+2, …, p (mod NUM_PORTS). Pointer updates only on a completed transfer.
- Not defined: fixed priority, port 0 highest; no pointer register. Starvation of higher indices is allowed.

## Structure
- Package `data_memory_pkg`: default `DATA_WIDTH`/`ADDR_WIDTH`, `RW_READ`=1, `RW_WRITE`=0 constants, byte-lane width constant 8.
- Sub-module `data_memory_arbiter` (`req`, pointer state → `gnt`, one-hot-to-index encode); top holds the array, write-mask logic and read register.

## Test plan
- Reset: hold `rst_n`=0 with `req`=all ones → `rvalid`=0, `data_out`=0; release → `gnt`=2'b01.
- Port 0 writes 0x1234 to 0x0001 with `be`=2'b11, next cycle reads 0x0001 → `rvalid[0]` one cycle later, `data_out`=0x1234.
- Byte enable: write 0xABCD to 0x0001 with `be`=2'b01 → read returns 0x12CD.
- Contention, fixed priority: both ports request continuously for 4 cycles → `gnt`=01 every cycle, port 1 never granted.
- Contention, RR build: both ports request for 4 cycles → `gnt` sequence 01,10,01,10; matching `rvalid` one cycle behind each read.
- Reset mid-read: port 1 read granted, `rst_n` dropped before next edge → `rvalid[1]` stays 0, `data_out`=0.
